alu_issue_ctrl: RTL and testbench

//  Drives the ALU: accepts one decoded-register instruction (11-bit LEGv8 opcode + operands)

---
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one decoded LEGv8 register-stage instruction, drives the
// combinational ALU with registered control/operands for one cycle, then holds the
// captured result and flags until the consumer takes them.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMMW  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [IMMW-1:0]  in_imm,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_illegal
);

    localparam int unsigned CTRLW = 4;

    localparam logic [CTRLW-1:0] CTRL_ADD  = 4'b0010;
    localparam logic [CTRLW-1:0] CTRL_SUB  = 4'b1010;
    localparam logic [CTRLW-1:0] CTRL_AND  = 4'b0110;
    localparam logic [CTRLW-1:0] CTRL_ORR  = 4'b0100;
    localparam logic [CTRLW-1:0] CTRL_EOR  = 4'b1001;
    localparam logic [CTRLW-1:0] CTRL_PASS = 4'b1101;
    localparam logic [CTRLW-1:0] CTRL_NOP  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CTRLW-1:0] dec_ctrl;
    logic             dec_use_imm;
    logic             dec_ill;
    logic [WIDTH-1:0] dec_b;
    logic             accept;
    logic             ill_q;
    logic [WIDTH-1:0] cap_res;

    // Opcode to ALU control translation; first matching row wins.
    always_comb begin
        dec_ctrl    = CTRL_NOP;
        dec_use_imm = 1'b0;
        dec_ill     = 1'b0;
        casez (in_opcode)
            11'b10001011000: dec_ctrl = CTRL_ADD;
            11'b11111000010,
            11'b11111000000: begin dec_ctrl = CTRL_ADD; dec_use_imm = 1'b1; end
            11'b1001000100?: begin dec_ctrl = CTRL_ADD; dec_use_imm = 1'b1; end
            11'b11001011000: dec_ctrl = CTRL_SUB;
            11'b1101000100?: begin dec_ctrl = CTRL_SUB; dec_use_imm = 1'b1; end
            11'b10001010000: dec_ctrl = CTRL_AND;
            11'b1001001000?: begin dec_ctrl = CTRL_AND; dec_use_imm = 1'b1; end
            11'b10101010000: dec_ctrl = CTRL_ORR;
            11'b1011001000?: begin dec_ctrl = CTRL_ORR; dec_use_imm = 1'b1; end
            11'b11001010000: dec_ctrl = CTRL_EOR;
            11'b1101001000?: begin dec_ctrl = CTRL_EOR; dec_use_imm = 1'b1; end
            11'b10110100???: dec_ctrl = CTRL_PASS;
            default:         dec_ill  = 1'b1;
        endcase
    end

    // Second operand: zero-extended immediate for I/D-type, register otherwise.
    always_comb begin
        dec_b = in_b;
        if (dec_use_imm) begin
            dec_b = WIDTH'(in_imm);
        end
    end

    // Handshake and capture qualifiers.
    always_comb begin
        accept  = (state == S_IDLE) && in_valid;
        cap_res = ill_q ? '0 : alu_result;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one cycle in EXEC, hold DONE until the consumer takes it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_EXEC;
            S_EXEC:                 state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Handshake flags follow the state being entered so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
        end
    end

    // ALU drive: loaded on accept, visible only during EXEC, parked otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl <= CTRL_NOP;
            alu_a    <= '0;
            alu_b    <= '0;
            ill_q    <= 1'b0;
        end else if (accept) begin
            alu_ctrl <= dec_ctrl;
            alu_a    <= in_a;
            alu_b    <= dec_b;
            ill_q    <= dec_ill;
        end else if (state == S_EXEC) begin
            alu_ctrl <= CTRL_NOP;
            alu_a    <= '0;
            alu_b    <= '0;
        end
    end

    // Result capture at the end of EXEC; illegal ops report a forced zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (state == S_EXEC) begin
            out_result  <= cap_res;
            out_zero    <= (cap_res == '0);
            out_neg     <= cap_res[WIDTH-1];
            out_illegal <= ill_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU on the alu_* port.
module tb_alu_issue_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IMMW  = 12;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [IMMW-1:0]  in_imm;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_illegal;

    int total;
    int bad;

    alu_issue_ctrl #(.WIDTH(WIDTH), .IMMW(IMMW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_imm      (in_imm),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; unknown codes return a non-zero pattern so forced zeros show.
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b1010: alu_result = alu_a - alu_b;
            4'b0110: alu_result = alu_a & alu_b;
            4'b0100: alu_result = alu_a | alu_b;
            4'b1001: alu_result = alu_a ^ alu_b;
            4'b1101: alu_result = alu_a;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full accept/execute/complete sequence with hand-computed expectations.
    task automatic run_op(input string tag, input logic [10:0] opc,
                          input logic [31:0] a, input logic [31:0] b, input logic [11:0] imm,
                          input logic [3:0] exp_ctrl, input logic [31:0] exp_b,
                          input logic [31:0] exp_res, input logic exp_zero,
                          input logic exp_neg, input logic exp_ill);
        @(negedge clk);
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_a      = a;
        in_b      = b;
        in_imm    = imm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
        check({tag, ".alu_b"}, alu_b, exp_b);
        check({tag, ".exec_vld"}, 32'(out_valid), 32'd0);
        check({tag, ".exec_rdy"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, ".vld"}, 32'(out_valid), 32'd1);
        check({tag, ".res"}, out_result, exp_res);
        check({tag, ".zero"}, 32'(out_zero), 32'(exp_zero));
        check({tag, ".neg"}, 32'(out_neg), 32'(exp_neg));
        check({tag, ".ill"}, 32'(out_illegal), 32'(exp_ill));
        check({tag, ".park"}, 32'(alu_ctrl), 32'h7);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst.rdy", 32'(in_ready), 32'd1);
        check("rst.vld", 32'(out_valid), 32'd0);
        check("rst.ctrl", 32'(alu_ctrl), 32'h7);
        check("rst.alu_a", alu_a, 32'd0);
        check("rst.alu_b", alu_b, 32'd0);
        check("rst.res", out_result, 32'd0);
        check("rst.zero", 32'(out_zero), 32'd0);
        check("rst.ill", 32'(out_illegal), 32'd0);

        // out_ready pulsed while idle must not disturb anything
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("idle_ordy.vld", 32'(out_valid), 32'd0);
        check("idle_ordy.rdy", 32'(in_ready), 32'd1);

        //     tag     opcode           a             b             imm     ctrl    alu_b         result        z     n     ill
        run_op("add",  11'b10001011000, 32'd5,        32'd7,        12'h0,  4'h2, 32'd7,        32'd12,       1'b0, 1'b0, 1'b0);
        run_op("sub0", 11'b11001011000, 32'd3,        32'd3,        12'h0,  4'hA, 32'd3,        32'd0,        1'b1, 1'b0, 1'b0);
        run_op("subn", 11'b11001011000, 32'd0,        32'd1,        12'h0,  4'hA, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        run_op("addi", 11'b10010001001, 32'hFFFFFFFF, 32'h55,       12'h001,4'h2, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0);
        run_op("and",  11'b10001010000, 32'hF0F0,     32'hFF00,     12'h0,  4'h6, 32'hFF00,     32'hF000,     1'b0, 1'b0, 1'b0);
        run_op("orri", 11'b10110010000, 32'h100,      32'h77,       12'h00F,4'h4, 32'hF,        32'h10F,      1'b0, 1'b0, 1'b0);
        run_op("eor",  11'b11001010000, 32'hFFFF0000, 32'hFFFFFFFF, 12'h0,  4'h9, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
        run_op("eori", 11'b11010010001, 32'h0F0,      32'h0,        12'hFFF,4'h9, 32'hFFF,      32'hF0F,      1'b0, 1'b0, 1'b0);
        run_op("subi", 11'b11010001000, 32'd10,       32'd99,       12'd4,  4'hA, 32'd4,        32'd6,        1'b0, 1'b0, 1'b0);
        run_op("cbz",  11'b10110100101, 32'h80000000, 32'd5,        12'h0,  4'hD, 32'd5,        32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("ldur", 11'b11111000010, 32'd100,      32'd999,      12'd8,  4'h2, 32'd8,        32'd108,      1'b0, 1'b0, 1'b0);
        run_op("ill",  11'b11111111111, 32'd9,        32'd4,        12'h0,  4'h7, 32'd4,        32'd0,        1'b1, 1'b0, 1'b1);

        // Consumer stall: results hold, no second accept while DONE
        @(negedge clk);
        in_valid  = 1'b1; in_opcode = 11'b10001011000; in_a = 32'd1; in_b = 32'd2;
        @(posedge clk); #1;
        in_opcode = 11'b11001011000; in_a = 32'd50; in_b = 32'd8;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("stall.vld", 32'(out_valid), 32'd1);
            check("stall.res", out_result, 32'd3);
            check("stall.ill", 32'(out_illegal), 32'd0);
            check("stall.rdy", 32'(in_ready), 32'd0);
            check("stall.park", 32'(alu_ctrl), 32'h7);
            @(posedge clk); #1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall.vld_drop", 32'(out_valid), 32'd0);
        check("stall.rdy_back", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("stall.no_take", 32'(alu_ctrl), 32'h7);
        check("stall.still_idle", 32'(in_ready), 32'd1);

        // Reset while EXEC drops the op
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 11'b10001011000; in_a = 32'd20; in_b = 32'd22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstx.exec_ctrl", 32'(alu_ctrl), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check("rstx.vld", 32'(out_valid), 32'd0);
        check("rstx.ctrl", 32'(alu_ctrl), 32'h7);
        check("rstx.alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rstx.post_vld", 32'(out_valid), 32'd0);
            check("rstx.post_rdy", 32'(in_ready), 32'd1);
            check("rstx.post_res", out_result, 32'd0);
        end

        // Normal operation resumes after the mid-flight reset
        run_op("after", 11'b10001011000, 32'd40, 32'd2, 12'h0, 4'h2, 32'd2, 32'd42, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
